// File: rtl/pulse_period_checker.sv
// Checks that pulse_in repeats every PERIOD cycles. Declares lock after LOCK_COUNT
// consecutive on-period pulses and flags violations seen while locked.
module pulse_period_checker #(
  parameter int PERIOD     = 3,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  output logic       locked,
  output logic       err,
  output logic [7:0] err_count,
  // "expect" is a reserved word, so the pulse-due flag carries this name
  output logic       expect_pulse
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [CNT_W-1:0] PER    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CYC_1  = CNT_W'(1);
  localparam logic [3:0]       LOCK_G = 4'(LOCK_COUNT);

  state_t           state, state_n;
  logic [CNT_W-1:0] cyc, cyc_n;
  logic [3:0]       good, good_n;
  logic             err_n;
  logic [7:0]       err_count_n;
  logic             at_period;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign at_period    = (cyc == PER);
  assign expect_pulse = (state != HUNT) && at_period;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      cyc       <= '0;
      good      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      cyc       <= cyc_n;
      good      <= good_n;
      locked    <= (state_n == LOCKED);
      err       <= err_n;
      err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    cyc_n       = cyc;
    good_n      = good;
    err_n       = 1'b0;
    err_count_n = err_count;
    case (state)
      HUNT: begin
        if (pulse_in) begin
          state_n = VERIFY;
          cyc_n   = CYC_1;
          good_n  = '0;
        end else begin
          cyc_n = '0;
        end
      end
      VERIFY: begin
        if (pulse_in) begin
          // Any pulse becomes the new reference; only on-period ones build credit
          cyc_n = CYC_1;
          if (at_period) begin
            good_n = good + 4'd1;
            if (good + 4'd1 == LOCK_G) state_n = LOCKED;
          end else begin
            good_n = '0;
          end
        end else if (at_period) begin
          state_n = HUNT;
          cyc_n   = '0;
          good_n  = '0;
        end else begin
          cyc_n = cyc + CYC_1;
        end
      end
      LOCKED: begin
        if (pulse_in) begin
          cyc_n = CYC_1;
          if (!at_period) begin
            state_n     = VERIFY;
            good_n      = '0;
            err_n       = 1'b1;
            err_count_n = sat_inc(err_count);
          end
        end else if (at_period) begin
          state_n     = HUNT;
          cyc_n       = '0;
          good_n      = '0;
          err_n       = 1'b1;
          err_count_n = sat_inc(err_count);
        end else begin
          cyc_n = cyc + CYC_1;
        end
      end
      default: begin
        state_n = HUNT;
        cyc_n   = '0;
        good_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_period_checker.sv
// Scoreboard bench for pulse_period_checker: the driver pushes expected outputs per
// cycle, a monitor pops and compares; directed constant checks at key scenario points.
module tb_pulse_period_checker;

  localparam int PERIOD     = 3;
  localparam int LOCK_COUNT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic       locked, err, expect_pulse;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  bit done  = 1'b0;

  logic [10:0] expq[$];

  // reference model state
  int ms = 0, mc = 0, mg = 0, mn = 0;
  bit ml = 1'b0, me = 1'b0;

  pulse_period_checker #(.PERIOD(PERIOD), .LOCK_COUNT(LOCK_COUNT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .locked(locked), .err(err), .err_count(err_count), .expect_pulse(expect_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model(input bit p, input bit r);
    if (r) begin
      ms = 0; mc = 0; mg = 0; mn = 0; ml = 0; me = 0;
    end else begin
      me = 0;
      case (ms)
        0: if (p) begin ms = 1; mc = 1; mg = 0; end else mc = 0;
        1: begin
          if (p) begin
            if (mc == PERIOD) begin mg++; if (mg == LOCK_COUNT) ms = 2; end
            else mg = 0;
            mc = 1;
          end else if (mc == PERIOD) begin ms = 0; mg = 0; mc = 0; end
          else mc++;
        end
        default: begin
          if (p) begin
            if (mc != PERIOD) begin ms = 1; mg = 0; me = 1; if (mn < 255) mn++; end
            mc = 1;
          end else if (mc == PERIOD) begin
            ms = 0; mg = 0; mc = 0; me = 1; if (mn < 255) mn++;
          end else mc++;
        end
      endcase
      ml = (ms == 2);
    end
  endtask

  task automatic step(input bit p, input bit r = 1'b0);
    logic [7:0] n8;
    @(negedge clk);
    pulse_in = p;
    reset    = r;
    model(p, r);
    n8 = mn[7:0];
    expq.push_back({ml, me, n8, (ms != 0) && (mc == PERIOD)});
    @(posedge clk);
    #2;
  endtask

  task automatic lock_seq();  // reference plus LOCK_COUNT on-period pulses
    step(1); step(0); step(0); step(1); step(0); step(0); step(1);
  endtask

  task automatic relock_after_early();
    step(0); step(0); step(1); step(0); step(0); step(1);
  endtask

  // monitor
  initial begin
    logic [10:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {locked, err, err_count, expect_pulse};
        tests++;
        if (g !== e) begin
          fails++;
          $display("FAIL cycle%0d outputs{locked,err,cnt,expect}: got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
                   cycle, g[10], g[9], g[8:1], g[0], e[10], e[9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    // reset state
    step(0, 1); step(0, 1);
    check("reset_locked", int'(locked), 0);
    check("reset_err", int'(err), 0);
    check("reset_count", int'(err_count), 0);
    check("reset_expect", int'(expect_pulse), 0);

    // pulses at edges 0,3,6 -> lock after edge 6
    step(1); step(0); step(0); step(1); step(0); step(0);
    check("prelock_locked", int'(locked), 0);
    check("prelock_expect", int'(expect_pulse), 1);
    step(1);
    check("lock_locked", int'(locked), 1);
    check("lock_err", int'(err), 0);

    // missed pulse at edge 9
    step(0); step(0); step(0);
    check("miss_err", int'(err), 1);
    check("miss_count", int'(err_count), 1);
    check("miss_locked", int'(locked), 0);
    check("miss_expect", int'(expect_pulse), 0);
    step(0);
    check("miss_err_onecycle", int'(err), 0);

    // relock, then early pulse one edge after lock
    lock_seq();
    check("relock1", int'(locked), 1);
    step(1);
    check("early_err", int'(err), 1);
    check("early_count", int'(err_count), 2);
    check("early_locked", int'(locked), 0);
    step(0); step(0); step(1); step(0); step(0);
    check("early_verify_nolock", int'(locked), 0);
    step(1);
    check("early_relock", int'(locked), 1);

    // three more early violations to reach err_count = 5, then reset while locked
    for (int i = 0; i < 3; i++) begin
      step(1);
      relock_after_early();
    end
    check("five_count", int'(err_count), 5);
    check("five_locked", int'(locked), 1);
    step(0, 1);
    check("rst_mid_locked", int'(locked), 0);
    check("rst_mid_count", int'(err_count), 0);
    check("rst_mid_err", int'(err), 0);
    check("rst_mid_expect", int'(expect_pulse), 0);
    lock_seq();
    check("rst_relock", int'(locked), 1);

    // pulse_in held high for 20 cycles
    step(0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("high_locked", int'(locked), 0);
      check("high_err", int'(err), 0);
    end

    // 260 locked-state violations, relocking between each
    step(0, 1);
    lock_seq();
    for (int i = 0; i < 260; i++) begin
      step(1);
      check("sat_err", int'(err), 1);
      check("sat_count", int'(err_count), (i + 1 > 255) ? 255 : i + 1);
      relock_after_early();
    end
    check("sat_final", int'(err_count), 255);

    step(0); step(0);
    done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!done && budget < 20000) begin
      @(posedge clk);
      budget++;
    end
    if (!done) check("timeout", 0, 1);
    repeat (3) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
